// File: rtl/rank_scan.sv
// ============================================================================
// rank_scan : scans a register-file range two entries per cycle and reports
//             the highest rank and its address (ties go to the lower address)
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rank_scan #(
  parameter int BW    = 6,
  parameter int COUNT = 32,
  parameter int ADDR  = $clog2(COUNT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [ADDR-1:0] lo_addr,
  input  logic [ADDR-1:0] hi_addr,
  output logic [ADDR-1:0] r1_addr,
  output logic [ADDR-1:0] r2_addr,
  input  logic [BW-1:0]   r1_data,
  input  logic [BW-1:0]   r2_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR-1:0] best_idx,
  output logic [BW-1:0]   best_rank
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR:0] PTR_ONE = (ADDR+1)'(1);
  localparam logic [ADDR:0] PTR_TWO = (ADDR+1)'(2);

  state_t          state_q, state_d;
  logic [ADDR:0]   ptr_q, ptr_d;
  logic [ADDR-1:0] hi_q, hi_d;
  logic            first_q, first_d;
  logic [ADDR-1:0] cur_idx_q, cur_idx_d;
  logic [BW-1:0]   cur_rank_q, cur_rank_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [ADDR-1:0] best_idx_q, best_idx_d;
  logic [BW-1:0]   best_rank_q, best_rank_d;

  logic [ADDR:0]   ptr_inc;
  logic [ADDR:0]   hi_ext;
  logic            last;
  logic [ADDR-1:0] win_idx;
  logic [BW-1:0]   win_rank;
  logic            take;
  logic [ADDR-1:0] nxt_idx;
  logic [BW-1:0]   nxt_rank;

  // The wide pointer keeps ptr+1 from wrapping when hi is the top entry.
  assign ptr_inc = ptr_q + PTR_ONE;
  assign hi_ext  = {1'b0, hi_q};
  assign last    = (ptr_inc >= hi_ext);

  assign r1_addr = (state_q == SCAN) ? ptr_q[ADDR-1:0] : '0;
  assign r2_addr = (state_q == SCAN) ? (last ? hi_q : ptr_inc[ADDR-1:0]) : '0;

  // Port 2 never addresses below port 1, so a tie resolves to port 1.
  always_comb begin
    if (r2_data > r1_data) begin
      win_idx  = r2_addr;
      win_rank = r2_data;
    end else begin
      win_idx  = r1_addr;
      win_rank = r1_data;
    end
  end

  assign take     = first_q || (win_rank > cur_rank_q);
  assign nxt_idx  = take ? win_idx  : cur_idx_q;
  assign nxt_rank = take ? win_rank : cur_rank_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    first_d     = first_q;
    cur_idx_d   = cur_idx_q;
    cur_rank_d  = cur_rank_q;
    err_d       = err_q;
    best_idx_d  = best_idx_q;
    best_rank_d = best_rank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hi_d    = hi_addr;
          ptr_d   = {1'b0, lo_addr};
          first_d = 1'b1;
          if (lo_addr <= hi_addr) begin
            state_d = SCAN;
            err_d   = 1'b0;
          end else begin
            state_d     = DONE;
            err_d       = 1'b1;
            best_idx_d  = '0;
            best_rank_d = '0;
          end
        end
      end
      SCAN: begin
        // Results are committed only on completion, so an abort leaves
        // the previous outputs untouched.
        if (abort) begin
          state_d = IDLE;
        end else begin
          first_d    = 1'b0;
          cur_idx_d  = nxt_idx;
          cur_rank_d = nxt_rank;
          ptr_d      = ptr_q + PTR_TWO;
          if (last) begin
            state_d     = DONE;
            best_idx_d  = nxt_idx;
            best_rank_d = nxt_rank;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hi_q        <= '0;
      first_q     <= 1'b0;
      cur_idx_q   <= '0;
      cur_rank_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      best_idx_q  <= '0;
      best_rank_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      first_q     <= first_d;
      cur_idx_q   <= cur_idx_d;
      cur_rank_q  <= cur_rank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      best_idx_q  <= best_idx_d;
      best_rank_q <= best_rank_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign best_idx  = best_idx_q;
  assign best_rank = best_rank_q;

endmodule

`default_nettype wire

// File: tb/tb_rank_scan.sv
// ============================================================================
// tb_rank_scan : directed bench for rank_scan with a result scoreboard
// Revision     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rank_scan;

  localparam int BW    = 6;
  localparam int COUNT = 32;
  localparam int ADDR  = 5;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic [ADDR-1:0] lo_addr;
  logic [ADDR-1:0] hi_addr;
  logic [ADDR-1:0] r1_addr;
  logic [ADDR-1:0] r2_addr;
  logic [BW-1:0]   r1_data;
  logic [BW-1:0]   r2_data;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR-1:0] best_idx;
  logic [BW-1:0]   best_rank;

  logic [BW-1:0] rf [COUNT];

  typedef struct {
    int cycles;
    int idx;
    int rank;
    int err;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  rank_scan #(.BW(BW), .COUNT(COUNT), .ADDR(ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .r1_addr   (r1_addr),
    .r2_addr   (r2_addr),
    .r1_data   (r1_data),
    .r2_data   (r2_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .best_idx  (best_idx),
    .best_rank (best_rank)
  );

  assign r1_data = rf[r1_addr];
  assign r2_data = rf[r2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Linear max search over the range; first occurrence wins a tie.
  function automatic exp_t model(input int lo, input int hi);
    exp_t e;
    e.cycles = 0;
    e.idx    = 0;
    e.rank   = 0;
    e.err    = 0;
    if (lo > hi) begin
      e.err = 1;
    end else begin
      e.cycles = (hi - lo + 2) / 2;
      e.idx    = lo;
      e.rank   = int'(rf[lo]);
      for (int i = lo + 1; i <= hi; i++) begin
        if (int'(rf[i]) > e.rank) begin
          e.idx  = i;
          e.rank = int'(rf[i]);
        end
      end
    end
    return e;
  endfunction

  task automatic run_scan(input int lo, input int hi);
    exp_t e;
    int   nb;
    int   r2e;
    sb.push_back(model(lo, hi));
    @(negedge clk);
    start   = 1'b1;
    lo_addr = ADDR'(lo);
    hi_addr = ADDR'(hi);
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      r2e = (lo + 2 * nb + 1 < hi) ? lo + 2 * nb + 1 : hi;
      chk($sformatf("r1_addr[%0d..%0d]#%0d", lo, hi, nb), 32'(r1_addr), 32'(lo + 2 * nb));
      chk($sformatf("r2_addr[%0d..%0d]#%0d", lo, hi, nb), 32'(r2_addr), 32'(r2e));
      nb++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk($sformatf("busy_cycles[%0d..%0d]", lo, hi), 32'(nb), 32'(e.cycles));
    chk($sformatf("done[%0d..%0d]", lo, hi), 32'(done), 32'd1);
    chk($sformatf("err[%0d..%0d]", lo, hi), 32'(err), 32'(e.err));
    chk($sformatf("best_idx[%0d..%0d]", lo, hi), 32'(best_idx), 32'(e.idx));
    chk($sformatf("best_rank[%0d..%0d]", lo, hi), 32'(best_rank), 32'(e.rank));
    @(negedge clk);
    chk($sformatf("done_pulse[%0d..%0d]", lo, hi), 32'(done), 32'd0);
    chk($sformatf("hold_idx[%0d..%0d]", lo, hi), 32'(best_idx), 32'(e.idx));
  endtask

  initial begin
    int seen_done;
    for (int i = 0; i < COUNT; i++) rf[i] = '0;
    rf[0] = 6'd12;
    for (int i = 1; i <= 4; i++) rf[i] = 6'd8;
    rf[5] = 6'd12;
    rf[6] = 6'd12;
    for (int i = 7; i <= 9; i++) rf[i] = 6'd30;
    rf[10] = 6'd12;
    rf[11] = 6'd10;

    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    lo_addr = '0;
    hi_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    chk("rst_best_rank", 32'(best_rank), 32'd0);
    chk("rst_r1_addr", 32'(r1_addr), 32'd0);

    run_scan(0, 11);
    run_scan(3, 3);
    run_scan(0, 31);
    run_scan(1, 8);
    run_scan(8, 10);
    run_scan(5, 2);
    run_scan(12, 31);

    // Abort on the third scan cycle with start held high the whole time.
    @(negedge clk);
    start   = 1'b1;
    lo_addr = 5'd0;
    hi_addr = 5'd11;
    @(negedge clk);
    chk("abort_r1_c1", 32'(r1_addr), 32'd0);
    @(negedge clk);
    chk("abort_r1_c2", 32'(r1_addr), 32'd2);
    @(negedge clk);
    chk("abort_r1_c3", 32'(r1_addr), 32'd4);
    abort = 1'b1;
    start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_best_idx", 32'(best_idx), 32'd12);
    chk("abort_best_rank", 32'(best_rank), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // Abort while idle changes nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_idx", 32'(best_idx), 32'd12);
    chk("idle_abort_busy", 32'(busy), 32'd0);

    run_scan(0, 11);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    start   = 1'b1;
    lo_addr = 5'd0;
    hi_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_best_idx", 32'(best_idx), 32'd0);
    chk("areset_best_rank", 32'(best_rank), 32'd0);
    chk("areset_r1_addr", 32'(r1_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("areset_no_done", 32'(seen_done), 32'd0);

    run_scan(1, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
